// File: rtl/multicycle_controller_pkg.sv
// Shared types for the RV32I multi-cycle control unit:
// FSM states, opcodes, ALU op codes and immediate selects.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_R,
      CLS_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH
   } cls_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam int ALU_W = 5;
   typedef logic [ALU_W-1:0] alu_op_t;

   localparam alu_op_t ALU_ADD  = 5'd0;
   localparam alu_op_t ALU_SUB  = 5'd1;
   localparam alu_op_t ALU_SLL  = 5'd2;
   localparam alu_op_t ALU_SLT  = 5'd3;
   localparam alu_op_t ALU_SLTU = 5'd4;
   localparam alu_op_t ALU_XOR  = 5'd5;
   localparam alu_op_t ALU_SRL  = 5'd6;
   localparam alu_op_t ALU_SRA  = 5'd7;
   localparam alu_op_t ALU_OR   = 5'd8;
   localparam alu_op_t ALU_AND  = 5'd9;

   localparam logic [1:0] IMM_I = 2'd0;
   localparam logic [1:0] IMM_S = 2'd1;
   localparam logic [1:0] IMM_B = 2'd2;

   typedef struct packed {
      cls_t    cls;
      alu_op_t alu_op;
      logic    illegal;
   } dec_t;

   // alt selects SUB/SRA; callers qualify it per instruction class
   function automatic alu_op_t f3_alu(input logic [2:0] f3,
                                      input logic       alt);
      alu_op_t op;
      unique case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction and data memory req/ack bus seen by the controller.
// master = controller side, slave = memory side.
interface multicycle_controller_if #(
   parameter int INSTR_W = 32
);
   logic [INSTR_W-1:0] instr;
   logic               imem_req;
   logic               imem_ack;
   logic               dmem_req;
   logic               dmem_we;
   logic               dmem_ack;

   modport master (
      output imem_req, dmem_req, dmem_we,
      input  instr, imem_ack, dmem_ack
   );

   modport slave (
      input  imem_req, dmem_req, dmem_we,
      output instr, imem_ack, dmem_ack
   );
endinterface

// File: rtl/multicycle_controller_decoder.sv
// Combinational RV32I decoder: instruction class, ALU op and
// illegal-encoding flag for the subset the controller supports.
module instr_decoder
   import rv_ctrl_pkg::*;
#(
   parameter int INSTR_W = 32
) (
   input  logic [INSTR_W-1:0] ir,
   output dec_t               dec
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       unused_fields;

   assign opc = ir[6:0];
   assign f3  = ir[14:12];
   assign f7  = ir[31:25];
   assign unused_fields = ^{ir[INSTR_W-1:32], ir[24:15], ir[11:7]};

   always_comb begin
      dec.cls     = CLS_NONE;
      dec.alu_op  = ALU_ADD;
      dec.illegal = 1'b1;
      unique case (opc)
         OP_R: begin
            dec.cls     = CLS_R;
            dec.alu_op  = f3_alu(f3, f7[5]);
            dec.illegal = !((f7 == 7'h00) ||
                            (f7 == 7'h20 &&
                             (f3 == 3'b000 || f3 == 3'b101)));
         end
         OP_I: begin
            dec.cls     = CLS_I;
            dec.alu_op  = f3_alu(f3, (f3 == 3'b101) && f7[5]);
            dec.illegal = (f3 == 3'b001 && f7 != 7'h00) ||
                          (f3 == 3'b101 && f7 != 7'h00 &&
                           f7 != 7'h20);
         end
         OP_LOAD: begin
            dec.cls     = CLS_LOAD;
            dec.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OP_STORE: begin
            dec.cls     = CLS_STORE;
            dec.illegal = (f3 > 3'b010);
         end
         OP_BRANCH: begin
            dec.cls     = CLS_BRANCH;
            dec.illegal = (f3[2:1] == 2'b01);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB FSM with
// req/ack memory handshakes, ack timeout and sticky trap flags.
module multicycle_controller
   import rv_ctrl_pkg::*;
#(
   parameter int INSTR_W  = 32,
   parameter int ALU_OP_W = 5,
   parameter int TIMEOUT  = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_controller_if.master bus,
   input  logic                  br_taken,
   output logic [ALU_OP_W-1:0]   alu_op,
   output logic                  sel_b,
   output logic [1:0]            imm_sel,
   output logic                  wb_sel,
   output logic                  regfile_write_enable,
   output logic                  pc_write,
   output logic                  pc_sel,
   output logic                  instr_retired,
   output logic                  illegal_instr,
   output logic                  bus_error
);

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t             state;
   state_t             state_n;
   logic [INSTR_W-1:0] ir;
   logic [15:0]        wait_cnt;
   logic               illegal_q;
   logic               bus_err_q;
   logic               waiting;
   logic               timeout;
   dec_t               dec;

   instr_decoder #(
      .INSTR_W (INSTR_W)
   ) u_dec (
      .ir  (ir),
      .dec (dec)
   );

   assign timeout = (wait_cnt == TMO);
   assign waiting = (state == S_FETCH && !bus.imem_ack) ||
                    (state == S_MEM   && !bus.dmem_ack);

   always_comb begin
      state_n = state;
      unique case (state)
         S_FETCH: begin
            if (bus.imem_ack)  state_n = S_DECODE;
            else if (timeout)  state_n = S_TRAP;
         end
         S_DECODE: state_n = dec.illegal ? S_TRAP : S_EXEC;
         S_EXEC: begin
            unique case (dec.cls)
               CLS_LOAD,
               CLS_STORE:  state_n = S_MEM;
               CLS_BRANCH: state_n = S_FETCH;
               default:    state_n = S_WB;
            endcase
         end
         S_MEM: begin
            if (bus.dmem_ack)
               state_n = (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
            else if (timeout)
               state_n = S_TRAP;
         end
         S_WB:    state_n = S_FETCH;
         default: state_n = S_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         ir        <= '0;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state <= state_n;
         if (state == S_FETCH && bus.imem_ack)
            ir <= bus.instr;
         // each handshake gets a fresh wait budget
         if (state_n != state &&
             (state_n == S_FETCH || state_n == S_MEM))
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + 16'd1;
         if (state == S_DECODE && dec.illegal)
            illegal_q <= 1'b1;
         if (state_n == S_TRAP &&
             (state == S_FETCH || state == S_MEM))
            bus_err_q <= 1'b1;
      end
   end

   always_comb begin
      bus.imem_req         = 1'b0;
      bus.dmem_req         = 1'b0;
      bus.dmem_we          = 1'b0;
      alu_op               = '0;
      sel_b                = 1'b0;
      imm_sel              = IMM_I;
      wb_sel               = 1'b0;
      regfile_write_enable = 1'b0;
      pc_write             = 1'b0;
      pc_sel               = 1'b0;
      instr_retired        = 1'b0;
      if (!rst) begin
         unique case (state)
            S_FETCH: bus.imem_req = 1'b1;
            S_EXEC: begin
               alu_op = ALU_OP_W'(dec.alu_op);
               sel_b  = dec.cls inside {CLS_I, CLS_LOAD, CLS_STORE};
               unique case (1'b1)
                  dec.cls == CLS_STORE:  imm_sel = IMM_S;
                  dec.cls == CLS_BRANCH: imm_sel = IMM_B;
                  default:               imm_sel = IMM_I;
               endcase
               if (dec.cls == CLS_BRANCH) begin
                  pc_write      = 1'b1;
                  pc_sel        = br_taken;
                  instr_retired = 1'b1;
               end
            end
            S_MEM: begin
               bus.dmem_req = 1'b1;
               bus.dmem_we  = (dec.cls == CLS_STORE);
               sel_b        = 1'b1;
               imm_sel      = (dec.cls == CLS_STORE) ? IMM_S : IMM_I;
               if (bus.dmem_ack && dec.cls == CLS_STORE) begin
                  pc_write      = 1'b1;
                  instr_retired = 1'b1;
               end
            end
            S_WB: begin
               regfile_write_enable = (ir[11:7] != 5'd0);
               wb_sel        = (dec.cls == CLS_LOAD);
               pc_write      = 1'b1;
               instr_retired = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign illegal_instr = illegal_q && !rst;
   assign bus_error     = bus_err_q && !rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions,
// monitor checks each retirement against the queued expectation.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       br_taken = 1'b0;
   logic [4:0] alu_op;
   logic       sel_b;
   logic [1:0] imm_sel;
   logic       wb_sel;
   logic       rf_we;
   logic       pc_write;
   logic       pc_sel;
   logic       instr_retired;
   logic       illegal_instr;
   logic       bus_error;

   multicycle_controller_if #(.INSTR_W(32)) bus();

   multicycle_controller #(
      .INSTR_W  (32),
      .ALU_OP_W (5),
      .TIMEOUT  (4)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .bus                  (bus),
      .br_taken             (br_taken),
      .alu_op               (alu_op),
      .sel_b                (sel_b),
      .imm_sel              (imm_sel),
      .wb_sel               (wb_sel),
      .regfile_write_enable (rf_we),
      .pc_write             (pc_write),
      .pc_sel               (pc_sel),
      .instr_retired        (instr_retired),
      .illegal_instr        (illegal_instr),
      .bus_error            (bus_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cycles;
      int alu;
      int selb;
      int imm;
      int we;
      int wbs;
      int pcs;
      int dcnt;
      int dwe;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   task automatic check(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic fail(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: handshake wait expired", nm);
   endtask

   function automatic exp_t mk(int cy, int al, int sb, int im, int we,
                               int wb, int ps, int dc, int dw);
      exp_t e;
      e.cycles = cy; e.alu = al; e.selb = sb; e.imm = im; e.we = we;
      e.wbs = wb; e.pcs = ps; e.dcnt = dc; e.dwe = dw;
      return e;
   endfunction

   function automatic int all_out();
      return int'({bus.imem_req, bus.dmem_req, bus.dmem_we, alu_op,
                   sel_b, imm_sel, wb_sel, rf_we, pc_write, pc_sel,
                   instr_retired, illegal_instr, bus_error});
   endfunction

   // monitor: counts cycles per instruction, captures EXEC controls
   int    m_cyc = 0;
   int    m_k = 0;
   int    m_dcnt = 0;
   int    m_dwe = 0;
   bit    m_act = 1'b0;
   int    c_alu = 0;
   int    c_selb = 0;
   int    c_imm = 0;
   exp_t  m_e;
   string m_nm;

   always @(negedge clk) begin
      if (rst) begin
         m_act = 1'b0; m_k = 0; m_dcnt = 0; m_dwe = 0; m_cyc = 0;
      end else begin
         if (!m_act && bus.imem_req) begin
            m_act = 1'b1;
            m_cyc = 0;
         end
         if (m_act) m_cyc++;
         if (m_k > 0) m_k++;
         if (m_k == 3) begin
            c_alu  = int'(alu_op);
            c_selb = int'(sel_b);
            c_imm  = int'(imm_sel);
         end
         if (bus.imem_req && bus.imem_ack) m_k = 1;
         if (bus.dmem_req) begin
            m_dcnt++;
            m_dwe = int'(bus.dmem_we);
         end
         if (instr_retired) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_retire: got retire, expected none");
            end else begin
               m_e  = exp_q.pop_front();
               m_nm = name_q.pop_front();
               check({m_nm, "_cycles"},  m_cyc, m_e.cycles);
               check({m_nm, "_alu_op"},  c_alu, m_e.alu);
               check({m_nm, "_sel_b"},   c_selb, m_e.selb);
               check({m_nm, "_imm_sel"}, c_imm, m_e.imm);
               check({m_nm, "_rf_we"},   int'(rf_we), m_e.we);
               check({m_nm, "_wb_sel"},  int'(wb_sel), m_e.wbs);
               check({m_nm, "_pc_sel"},  int'(pc_sel), m_e.pcs);
               check({m_nm, "_pc_write"}, int'(pc_write), 1);
               check({m_nm, "_dmem_cyc"}, m_dcnt, m_e.dcnt);
               check({m_nm, "_dmem_we"},  m_dwe, m_e.dwe);
            end
            m_act = 1'b0; m_dcnt = 0; m_dwe = 0; m_k = 0;
         end
      end
   end

   task automatic serve_fetch(input logic [31:0] w, input int waits,
                              input bit br, output bit ok);
      int t = 0;
      ok = 1'b0;
      while (!bus.imem_req && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!bus.imem_req) return;
      br_taken = br;
      repeat (waits) begin @(posedge clk); #1; end
      bus.instr    = w;
      bus.imem_ack = 1'b1;
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      bus.instr    = '0;
      ok = 1'b1;
   endtask

   task automatic serve_mem(input int waits, output bit ok);
      int t = 0;
      ok = 1'b0;
      while (!bus.dmem_req && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!bus.dmem_req) return;
      repeat (waits) begin @(posedge clk); #1; end
      bus.dmem_ack = 1'b1;
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
      ok = 1'b1;
   endtask

   task automatic issue(input string nm, input logic [31:0] w,
                        input int fw, input bit mem, input int mw,
                        input bit br, input exp_t e);
      bit ok;
      exp_q.push_back(e);
      name_q.push_back(nm);
      serve_fetch(w, fw, br, ok);
      if (!ok) begin fail({nm, "_fetch"}); return; end
      if (mem) begin
         serve_mem(mw, ok);
         if (!ok) fail({nm, "_mem"});
      end
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      while (!bus.imem_req && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!bus.imem_req) fail({nm, "_idle"});
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      #1;
      check({nm, "_outputs_in_reset"}, all_out(), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check({nm, "_imem_req_after"}, int'(bus.imem_req), 1);
      check({nm, "_illegal_cleared"}, int'(illegal_instr), 0);
      check({nm, "_bus_error_cleared"}, int'(bus_error), 0);
   endtask

   logic [31:0] bad_w[3];

   initial begin
      bit ok;
      bus.instr    = '0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", all_out(), 0);
      rst = 1'b0;
      #1;
      check("first_imem_req", int'(bus.imem_req), 1);

      issue("add",   32'h002081B3, 0, 0, 0, 0, mk(4,0,0,0,1,0,0,0,0));
      issue("sub",   32'h402081B3, 0, 0, 0, 0, mk(4,1,0,0,1,0,0,0,0));
      issue("srai",  32'h40335293, 0, 0, 0, 0, mk(4,7,1,0,1,0,0,0,0));
      issue("lw",    32'h0080A203, 0, 1, 3, 0, mk(8,0,1,0,1,1,0,4,0));
      issue("sw",    32'h0020A223, 0, 1, 0, 0, mk(4,0,1,1,0,0,0,1,1));
      issue("beq_t", 32'h00208463, 0, 0, 0, 1, mk(3,0,0,2,0,0,1,0,0));
      issue("beq_n", 32'h00208463, 0, 0, 0, 0, mk(3,0,0,2,0,0,0,0,0));
      issue("add_x0", 32'h00208033, 0, 0, 0, 0, mk(4,0,0,0,0,0,0,0,0));
      issue("slli_w2", 32'h00209093, 2, 0, 0, 0, mk(6,2,1,0,1,0,0,0,0));
      issue("xor_w4", 32'h0020C1B3, 4, 0, 0, 0, mk(8,5,0,0,1,0,0,0,0));
      issue("sw_w4", 32'h0020A223, 0, 1, 4, 0, mk(8,0,1,1,0,0,0,5,1));
      wait_idle("seq");
      check("queue_drained", exp_q.size(), 0);

      bad_w[0] = 32'hFFFFFFFF;
      bad_w[1] = 32'h0000B003;
      bad_w[2] = 32'h40209093;
      for (int i = 0; i < 3; i++) begin
         serve_fetch(bad_w[i], 0, 1'b0, ok);
         if (!ok) fail("illegal_fetch");
         @(posedge clk); #1;
         check($sformatf("illegal%0d_flag", i), int'(illegal_instr), 1);
         check($sformatf("illegal%0d_no_req", i), int'(bus.imem_req), 0);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("illegal%0d_sticky", i), int'(illegal_instr), 1);
         check($sformatf("illegal%0d_stuck", i), all_out(), 2);
         do_reset($sformatf("rst_ill%0d", i));
      end

      repeat (4) @(posedge clk);
      #1;
      check("tmo_not_yet", int'(bus_error), 0);
      check("tmo_still_req", int'(bus.imem_req), 1);
      @(posedge clk); #1;
      check("tmo_bus_error", int'(bus_error), 1);
      check("tmo_no_req", int'(bus.imem_req), 0);
      repeat (2) @(posedge clk);
      #1;
      check("tmo_sticky", int'(bus_error), 1);
      do_reset("rst_tmo");

      serve_fetch(32'h0080A203, 0, 1'b0, ok);
      if (!ok) fail("midmem_fetch");
      begin
         int t = 0;
         while (!bus.dmem_req && t < 20) begin
            @(posedge clk); #1; t++;
         end
      end
      check("midmem_dmem_req", int'(bus.dmem_req), 1);
      do_reset("rst_midmem");
      check("midmem_dmem_dropped", int'(bus.dmem_req), 0);

      issue("add_after", 32'h002081B3, 0, 0, 0, 0, mk(4,0,0,0,1,0,0,0,0));
      wait_idle("final");
      check("final_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
